// File: rtl/dwrr_output_scheduler.sv
// Deficit-weighted round-robin packet scheduler: merges C_NUM_QUEUES AXI-Stream
// queues onto one egress port via a cut-through combinational mux.
module dwrr_output_scheduler #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_QUEUES       = 4,
   parameter int C_NUM_QUEUES_WIDTH = 2,
   parameter int C_QUANTUM_WIDTH    = 16,
   parameter int C_DEFICIT_WIDTH    = 18,
   parameter int C_DEFAULT_QUANTUM  = 1500
) (
   input  logic                                          axis_clk,
   input  logic                                          aresetn,
   input  logic [C_NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [C_NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic [C_NUM_QUEUES-1:0]                       s_axis_tlast,
   input  logic [C_NUM_QUEUES-1:0]                       s_axis_tvalid,
   output logic [C_NUM_QUEUES-1:0]                       s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
   output logic                                          m_axis_tlast,
   output logic                                          m_axis_tvalid,
   input  logic                                          m_axis_tready,
   input  logic                                          cfg_wr_en,
   input  logic [C_NUM_QUEUES_WIDTH-1:0]                 cfg_wr_queue,
   input  logic [C_QUANTUM_WIDTH-1:0]                    cfg_wr_quantum,
   output logic [C_NUM_QUEUES_WIDTH-1:0]                 stat_grant_queue,
   output logic                                          stat_busy
);

   localparam int KW = C_AXIS_DATA_WIDTH / 8;
   localparam logic [1:0] ST_ADD   = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [C_DEFICIT_WIDTH-1:0] DEFICIT_MAX = '1;

   logic [1:0]                    state_q, state_d;
   logic [C_NUM_QUEUES_WIDTH-1:0] cur_q, cur_d, cur_wrap;
   logic [C_DEFICIT_WIDTH-1:0]    deficit_q [C_NUM_QUEUES];
   logic [C_DEFICIT_WIDTH-1:0]    deficit_d [C_NUM_QUEUES];
   logic [C_QUANTUM_WIDTH-1:0]    quantum_q [C_NUM_QUEUES];

   logic                          sel_valid;
   logic [C_DEFICIT_WIDTH-1:0]    deficit_cur;
   logic [C_QUANTUM_WIDTH-1:0]    quantum_cur;
   logic [C_DEFICIT_WIDTH:0]      credit_sum;
   logic [C_DEFICIT_WIDTH-1:0]    credit_sat;
   logic [15:0]                   len_eff;
   logic                          len_fits;

   always_comb begin
      m_axis_tdata = s_axis_tdata[C_AXIS_DATA_WIDTH-1:0];
      m_axis_tkeep = s_axis_tkeep[KW-1:0];
      m_axis_tuser = s_axis_tuser[C_AXIS_TUSER_WIDTH-1:0];
      m_axis_tlast = s_axis_tlast[0];
      sel_valid    = s_axis_tvalid[0];
      for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
         if (cur_q == C_NUM_QUEUES_WIDTH'(i)) begin
            m_axis_tdata = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            m_axis_tkeep = s_axis_tkeep[i*KW +: KW];
            m_axis_tuser = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
            m_axis_tlast = s_axis_tlast[i];
            sel_valid    = s_axis_tvalid[i];
         end
      end
   end

   always_comb begin
      s_axis_tready = '0;
      for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
         s_axis_tready[i] = (state_q == ST_SEND) && (cur_q == C_NUM_QUEUES_WIDTH'(i)) && m_axis_tready;
      end
   end

   assign m_axis_tvalid    = (state_q == ST_SEND) && sel_valid;
   assign stat_busy        = (state_q == ST_SEND);
   assign stat_grant_queue = cur_q;

   assign deficit_cur = deficit_q[cur_q];
   assign quantum_cur = quantum_q[cur_q];
   assign credit_sum  = {1'b0, deficit_cur} + (C_DEFICIT_WIDTH+1)'(quantum_cur);
   assign credit_sat  = credit_sum[C_DEFICIT_WIDTH] ? DEFICIT_MAX : credit_sum[C_DEFICIT_WIDTH-1:0];
   // Zero-length packets still cost one byte of credit.
   assign len_eff     = (m_axis_tuser[15:0] == 16'd0) ? 16'd1 : m_axis_tuser[15:0];
   assign len_fits    = C_DEFICIT_WIDTH'(len_eff) <= deficit_cur;
   assign cur_wrap    = (cur_q == C_NUM_QUEUES_WIDTH'(C_NUM_QUEUES-1)) ? '0 : cur_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      for (int unsigned i = 0; i < C_NUM_QUEUES; i++) deficit_d[i] = deficit_q[i];
      case (state_q)
         ST_ADD: begin
            deficit_d[cur_q] = credit_sat;
            state_d          = ST_CHECK;
         end
         ST_CHECK: begin
            if (!sel_valid) begin
               deficit_d[cur_q] = '0;
               cur_d            = cur_wrap;
               state_d          = ST_ADD;
            end else if (len_fits) begin
               deficit_d[cur_q] = deficit_cur - C_DEFICIT_WIDTH'(len_eff);
               state_d          = ST_SEND;
            end else begin
               cur_d   = cur_wrap;
               state_d = ST_ADD;
            end
         end
         ST_SEND: begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = ST_CHECK;
         end
         default: state_d = ST_ADD;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         state_q <= ST_ADD;
         cur_q   <= '0;
         for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
            deficit_q[i] <= '0;
            quantum_q[i] <= C_QUANTUM_WIDTH'(C_DEFAULT_QUANTUM);
         end
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
            deficit_q[i] <= deficit_d[i];
            if (cfg_wr_en && (cfg_wr_queue == C_NUM_QUEUES_WIDTH'(i))) quantum_q[i] <= cfg_wr_quantum;
         end
      end
   end

endmodule

// File: tb/tb_dwrr_output_scheduler.sv
// Directed bench for dwrr_output_scheduler: per-queue packet sources, cycle-exact
// grant/latency checks and an output beat log.
module tb_dwrr_output_scheduler;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int UW = 128;

   logic              axis_clk = 1'b0;
   logic              aresetn  = 1'b0;
   logic [N*DW-1:0]   s_axis_tdata;
   logic [N*KW-1:0]   s_axis_tkeep;
   logic [N*UW-1:0]   s_axis_tuser;
   logic [N-1:0]      s_axis_tlast;
   logic [N-1:0]      s_axis_tvalid;
   logic [N-1:0]      s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [KW-1:0]     m_axis_tkeep;
   logic [UW-1:0]     m_axis_tuser;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b1;
   logic              cfg_wr_en = 1'b0;
   logic [1:0]        cfg_wr_queue = '0;
   logic [15:0]       cfg_wr_quantum = '0;
   logic [1:0]        stat_grant_queue;
   logic              stat_busy;

   dwrr_output_scheduler #(
      .C_AXIS_DATA_WIDTH (DW),
      .C_AXIS_TUSER_WIDTH(UW),
      .C_NUM_QUEUES      (N),
      .C_NUM_QUEUES_WIDTH(2),
      .C_QUANTUM_WIDTH   (16),
      .C_DEFICIT_WIDTH   (18),
      .C_DEFAULT_QUANTUM (1500)
   ) dut (
      .axis_clk        (axis_clk),
      .aresetn         (aresetn),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tuser    (s_axis_tuser),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .cfg_wr_en       (cfg_wr_en),
      .cfg_wr_queue    (cfg_wr_queue),
      .cfg_wr_quantum  (cfg_wr_quantum),
      .stat_grant_queue(stat_grant_queue),
      .stat_busy       (stat_busy)
   );

   always #5 axis_clk = ~axis_clk;

   int checks   = 0;
   int failures = 0;

   // Source model: each beat carries {queue, packet number, beat index} in tdata[23:0].
   int pkts [N];
   int nbeats [N];
   int bytes0 [N];
   int bytes1 [N];
   int bidx [N];
   int pktno [N];

   logic [23:0] log_id [$];
   logic        log_last [$];
   logic [7:0]  pkt_q [$];
   logic        q1_inflight;
   logic        leak;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int q = 0; q < N; q++) begin
         s_axis_tvalid[q] = (pkts[q] > 0);
         s_axis_tdata[q*DW +: DW] = '0;
         s_axis_tdata[q*DW +: 24] = {8'(q), 8'(pktno[q]), 8'(bidx[q])};
         s_axis_tkeep[q*KW +: KW] = '1;
         s_axis_tuser[q*UW +: UW] = UW'((pktno[q] == 0) ? bytes0[q] : bytes1[q]);
         s_axis_tlast[q] = (bidx[q] == nbeats[q] - 1);
      end
   endtask

   task automatic load(input int q, input int n, input int beats, input int b0, input int b1);
      pkts[q] = n; nbeats[q] = beats; bytes0[q] = b0; bytes1[q] = b1;
      bidx[q] = 0; pktno[q] = 0;
      drive();
   endtask

   task automatic cycle();
      logic [N-1:0] pop;
      #1;
      if (q1_inflight && (s_axis_tready[0] || s_axis_tready[3])) leak = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
         log_id.push_back(m_axis_tdata[23:0]);
         log_last.push_back(m_axis_tlast);
         if (m_axis_tlast) pkt_q.push_back(m_axis_tdata[23:16]);
         if (m_axis_tdata[23:16] == 8'd1) q1_inflight = !m_axis_tlast;
      end
      pop = s_axis_tready & s_axis_tvalid;
      @(posedge axis_clk);
      #1;
      for (int q = 0; q < N; q++) begin
         if (pop[q]) begin
            bidx[q]++;
            if (bidx[q] == nbeats[q]) begin
               bidx[q] = 0; pkts[q]--; pktno[q]++;
            end
         end
      end
      drive();
      #1;
   endtask

   task automatic reset_dut();
      aresetn = 1'b0;
      cfg_wr_en = 1'b0;
      m_axis_tready = 1'b1;
      for (int q = 0; q < N; q++) load(q, 0, 1, 0, 0);
      cycle();
      cycle();
      log_id.delete(); log_last.delete(); pkt_q.delete();
      q1_inflight = 1'b0; leak = 1'b0;
   endtask

   initial begin
      int seen;
      int pat [4];
      pat = '{1, 0, 0, 1};

      // 1: single 3-beat packet on q2 with default quanta
      reset_dut();
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("rst_tready", 64'(s_axis_tready), 64'(0));
      chk("rst_busy", 64'(stat_busy), 64'(0));
      chk("rst_grant", 64'(stat_grant_queue), 64'(0));
      load(2, 1, 3, 96, 96);
      aresetn = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (c == 4) chk("t1_grant_c4", 64'(stat_grant_queue), 64'(2));
         if (m_axis_tvalid || (|s_axis_tready)) seen++;
         cycle();
      end
      chk("t1_idle_c0_5", 64'(seen), 64'(0));
      chk("t1_c6_tvalid", 64'(m_axis_tvalid), 64'(1));
      chk("t1_c6_tready", 64'(s_axis_tready), 64'(4'b0100));
      chk("t1_c6_id", 64'(m_axis_tdata[23:0]), 64'(24'h020000));
      chk("t1_c6_busy", 64'(stat_busy), 64'(1));
      cycle();
      chk("t1_c7_id", 64'(m_axis_tdata[23:0]), 64'(24'h020001));
      chk("t1_c7_tlast", 64'(m_axis_tlast), 64'(0));
      cycle();
      chk("t1_c8_id", 64'(m_axis_tdata[23:0]), 64'(24'h020002));
      chk("t1_c8_tlast", 64'(m_axis_tlast), 64'(1));
      chk("t1_c8_tready", 64'(s_axis_tready), 64'(4'b0100));
      cycle();
      chk("t1_c9_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("t1_c9_tready", 64'(s_axis_tready), 64'(0));
      chk("t1_c9_deficit2", 64'(dut.deficit_q[2]), 64'(1404));
      cycle();
      chk("t1_c10_deficit2", 64'(dut.deficit_q[2]), 64'(0));
      chk("t1_c10_grant", 64'(stat_grant_queue), 64'(3));

      // 2: weighted ratio 3000:1000 with 1000-byte packets
      reset_dut();
      aresetn = 1'b1;
      cfg_wr_en = 1'b1; cfg_wr_queue = 2'd0; cfg_wr_quantum = 16'd3000;
      cycle();
      cfg_wr_queue = 2'd1; cfg_wr_quantum = 16'd1000;
      cycle();
      cfg_wr_en = 1'b0;
      repeat (4) cycle();
      chk("t2_grant_c6", 64'(stat_grant_queue), 64'(3));
      load(0, 40, 2, 1000, 1000);
      load(1, 40, 2, 1000, 1000);
      for (int c = 0; c < 2000 && pkt_q.size() < 40; c++) cycle();
      chk("t2_pkt_count", 64'(pkt_q.size() >= 40), 64'(1));
      for (int p = 0; p < 40; p++) begin
         chk("t2_order", 64'((p < pkt_q.size()) ? pkt_q[p] : 8'hFF), 64'((p % 4 == 3) ? 1 : 0));
      end

      // 3: 1600-byte packet skipped on first visit, granted on second
      reset_dut();
      load(0, 1, 2, 1600, 1600);
      aresetn = 1'b1;
      cycle(); cycle();
      chk("t3_c2_deficit0", 64'(dut.deficit_q[0]), 64'(1500));
      chk("t3_c2_grant", 64'(stat_grant_queue), 64'(1));
      chk("t3_c2_tvalid", 64'(m_axis_tvalid), 64'(0));
      repeat (6) cycle();
      chk("t3_c8_grant", 64'(stat_grant_queue), 64'(0));
      cycle(); cycle();
      chk("t3_c10_tvalid", 64'(m_axis_tvalid), 64'(1));
      chk("t3_c10_deficit0", 64'(dut.deficit_q[0]), 64'(1400));
      chk("t3_c10_id", 64'(m_axis_tdata[23:0]), 64'(24'h000000));
      cycle();
      chk("t3_c11_tlast", 64'(m_axis_tlast), 64'(1));
      cycle(); cycle();
      chk("t3_c13_deficit0", 64'(dut.deficit_q[0]), 64'(0));
      chk("t3_c13_grant", 64'(stat_grant_queue), 64'(1));

      // 4: toggling downstream ready across q0, q1 (8 beats), q3
      reset_dut();
      load(0, 1, 2, 64, 64);
      load(1, 1, 8, 256, 256);
      load(3, 1, 2, 64, 64);
      aresetn = 1'b1;
      for (int c = 0; c < 400 && log_id.size() < 12; c++) begin
         m_axis_tready = pat[c % 4][0];
         cycle();
      end
      m_axis_tready = 1'b1;
      repeat (10) cycle();
      chk("t4_beat_count", 64'(log_id.size()), 64'(12));
      for (int b = 0; b < 12; b++) begin
         logic [23:0] exp_id;
         if (b < 2)       exp_id = {8'd0, 8'd0, 8'(b)};
         else if (b < 10) exp_id = {8'd1, 8'd0, 8'(b - 2)};
         else             exp_id = {8'd3, 8'd0, 8'(b - 10)};
         chk("t4_beat_id", 64'((b < log_id.size()) ? log_id[b] : 24'hFFFFFF), 64'(exp_id));
      end
      chk("t4_q1_tlast", 64'((log_last.size() > 9) ? log_last[9] : 1'b0), 64'(1));
      chk("t4_no_leak", 64'(leak), 64'(0));

      // 5: reset pulse during the third beat of a q3 packet
      reset_dut();
      load(3, 1, 6, 192, 192);
      aresetn = 1'b1;
      cfg_wr_en = 1'b1; cfg_wr_queue = 2'd3; cfg_wr_quantum = 16'd700;
      cycle();
      cfg_wr_en = 1'b0;
      repeat (9) cycle();
      chk("t5_c10_quantum3", 64'(dut.quantum_q[3]), 64'(700));
      chk("t5_c10_id", 64'(m_axis_tdata[23:0]), 64'(24'h030002));
      chk("t5_c10_tvalid", 64'(m_axis_tvalid), 64'(1));
      aresetn = 1'b0;
      cycle();
      aresetn = 1'b1;
      chk("t5_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("t5_rst_tready", 64'(s_axis_tready), 64'(0));
      chk("t5_rst_grant", 64'(stat_grant_queue), 64'(0));
      chk("t5_rst_busy", 64'(stat_busy), 64'(0));
      chk("t5_rst_quantum3", 64'(dut.quantum_q[3]), 64'(1500));

      // 6: quantum rewrite on q1 while its packet is in flight
      reset_dut();
      load(1, 2, 4, 1400, 1300);
      aresetn = 1'b1;
      repeat (4) cycle();
      chk("t6_c4_tvalid", 64'(m_axis_tvalid), 64'(1));
      chk("t6_c4_id", 64'(m_axis_tdata[23:0]), 64'(24'h010000));
      chk("t6_c4_deficit1", 64'(dut.deficit_q[1]), 64'(100));
      cycle();
      cfg_wr_en = 1'b1; cfg_wr_queue = 2'd1; cfg_wr_quantum = 16'd200;
      cycle();
      cfg_wr_en = 1'b0;
      chk("t6_c6_quantum1", 64'(dut.quantum_q[1]), 64'(200));
      chk("t6_c6_id", 64'(m_axis_tdata[23:0]), 64'(24'h010002));
      cycle();
      chk("t6_c7_id", 64'(m_axis_tdata[23:0]), 64'(24'h010003));
      chk("t6_c7_tlast", 64'(m_axis_tlast), 64'(1));
      cycle();
      chk("t6_c8_tvalid", 64'(m_axis_tvalid), 64'(0));
      cycle();
      chk("t6_c9_grant", 64'(stat_grant_queue), 64'(2));
      chk("t6_c9_deficit1", 64'(dut.deficit_q[1]), 64'(100));
      repeat (7) cycle();
      chk("t6_c16_grant", 64'(stat_grant_queue), 64'(1));
      chk("t6_c16_deficit1", 64'(dut.deficit_q[1]), 64'(300));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dwrr_output_scheduler.md
Name: dwrr_output_scheduler

Overview:
- Deficit-weighted round-robin (DWRR) packet scheduler that merges C_NUM_QUEUES AXI-Stream queues onto one output port.
- Sits between the per-queue fallthrough FIFOs and the egress port. Each FIFO's non-empty flag arrives as s_axis_tvalid[i].
- Arbitration is per packet, never per beat. Each queue's bandwidth share follows a runtime-programmable byte quantum.
- Data path is zero-latency cut-through: a combinational mux, no internal buffering.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width
C_AXIS_TUSER_WIDTH, 128, tuser width; tuser[15:0] of first beat = packet length in bytes
C_NUM_QUEUES, 4, number of input queues
C_NUM_QUEUES_WIDTH, 2, clog2(C_NUM_QUEUES)
C_QUANTUM_WIDTH, 16, quantum register width
C_DEFICIT_WIDTH, 18, deficit counter width (saturating)
C_DEFAULT_QUANTUM, 1500, quantum of every queue after reset

Ports:
axis_clk  in  1  clock
aresetn  in  1  reset, synchronous, active-low; clock axis_clk
s_axis_tdata  in  N*C_AXIS_DATA_WIDTH  queue i data at slice i
s_axis_tkeep  in  N*C_AXIS_DATA_WIDTH/8  byte enables per queue
s_axis_tuser  in  N*C_AXIS_TUSER_WIDTH  metadata per queue
s_axis_tlast  in  N  end of packet per queue
s_axis_tvalid  in  N  head beat valid (queue non-empty)
s_axis_tready  out  N  pop strobe to queue i
m_axis_tdata  out  C_AXIS_DATA_WIDTH  output data
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  output keep
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  output tuser
m_axis_tlast  out  1  output last
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
cfg_wr_en  in  1  quantum write strobe
cfg_wr_queue  in  C_NUM_QUEUES_WIDTH  target queue
cfg_wr_quantum  in  C_QUANTUM_WIDTH  new quantum in bytes
stat_grant_queue  out  C_NUM_QUEUES_WIDTH  current queue pointer
stat_busy  out  1  high while in SEND

Behaviour:
- Registers and reset values:
  - cur (reset 0); state (reset ADD).
  - deficit[i] (reset 0); quantum[i] (reset C_DEFAULT_QUANTUM).
  - Reset outputs: m_axis_tvalid=0, s_axis_tready=0, stat_busy=0, stat_grant_queue=0. m_axis_tdata/tkeep/tuser/tlast show queue 0 slice (don't-care).
- Mux:
  - m_axis_{tdata,tkeep,tuser,tlast} = slice[cur], combinational.
  - m_axis_tvalid = (state==SEND) & s_axis_tvalid[cur].
  - s_axis_tready[i] = (state==SEND) & (i==cur) & m_axis_tready. All other queues see 0.
- len = s_axis_tuser[cur][15:0]; len==0 is treated as 1.
- State ADD (1 cycle):
  - deficit[cur] <= min(deficit[cur]+quantum[cur], 2^C_DEFICIT_WIDTH-1).
  - Then go to CHECK.
- State CHECK (1 cycle):
  - If !s_axis_tvalid[cur]: deficit[cur] <= 0, cur <= cur+1 (wrap N-1→0), go to ADD.
  - Else if len <= deficit[cur]: deficit[cur] <= deficit[cur]-len, go to SEND.
  - Else: deficit kept, cur advances with wrap, go to ADD.
- State SEND:
  - Forward beats on every m_axis_tvalid & m_axis_tready.
  - On handshake with tlast=1, go to CHECK on the same queue without re-adding the quantum.
  - cur never changes in SEND.
- Latency: first beat of a granted packet is presented 2 cycles after the queue pointer arrives (ADD, then CHECK). Back-to-back packets from the same queue have a 1-cycle CHECK bubble.
- Backpressure: m_axis_tready low holds the beat and cur. If s_axis_tvalid[cur] drops mid-packet, the FSM stays in SEND and outputs tvalid=0.
- All queues empty: pointer rotates one queue per 2 cycles and every deficit is cleared.
- Config write:
  - quantum[cfg_wr_queue] updates the cycle after cfg_wr_en.
  - Takes effect at that queue's next ADD; never affects the packet in flight.
  - Quantum 0 is legal: that queue accumulates no credit and is starved.
- Packets with len > 2^C_DEFICIT_WIDTH-1 are never granted. Upstream guarantees len ≤ 9600.
- Reset asserted mid-packet: the next cycle has all reset values. The partial packet is abandoned; upstream flushes it.

Test Plan:
1. Defaults; one 3-beat packet on q2, len=96; m_axis_tready=1 → beats on m_axis in cycles 6-8 after reset release (ADD/CHECK of q0, q1, then ADD/CHECK of q2). s_axis_tready[2] high for those 3 cycles only. deficit[2] = 0 after the next CHECK sees q2 empty.
2. quantum q0=3000, q1=1000; q0 and q1 continuously backlogged with 1000-byte packets → output packet order repeats q0,q0,q0,q1 over 40 packets.
3. quantum q0=1500; single 1600-byte packet on q0 → skipped first visit (deficit 1500). Granted second visit (deficit 3000→1400), then deficit 0 once q0 is empty.
4. m_axis_tready toggling 1,0,0,1 during an 8-beat packet on q1, with q0/q3 valid → all 8 beats in order, no duplicates. No other queue's tready rises before tlast.
5. aresetn low for 1 cycle during beat 3 of a q3 packet → next cycle m_axis_tvalid=0, s_axis_tready=0, stat_grant_queue=0, quanta=1500.
6. cfg write q1=200 during SEND of q1 → current packet completes unchanged. The next ADD on q1 adds 200.
